// File: rtl/vector_uram_pkg.sv
// Shared definitions for the URAM vector store reader/writer pair:
// default geometry, FSM state encoding and the reserved empty address.
package vector_uram_pkg;

  localparam int SIZE_DEF   = 256;
  localparam int ADDR_W_DEF = 6;
  localparam int SETTLE_DEF = 2;
  localparam int RSVD_ADDR  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/vector_uram_writer.sv
// Streams a burst of vectors into the URAM vector store at consecutive nonzero
// addresses, then pulses done once the last write is readable (URAM latency).
module vector_uram_writer
  import vector_uram_pkg::*;
#(
  parameter int Size   = SIZE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Size-1:0]   in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [Size-1:0]   mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  // Valid/ready: a beat is transferred on a rising edge where in_valid and
  // in_ready are both high; the source must hold in_valid/in_data until then.

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic                err_q, err_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [Size-1:0]     din_q;
  logic                ready;
  logic                beat;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    remain_d = remain_q;
    settle_d = settle_q;
    err_d    = 1'b0;
    ready    = 1'b0;
    beat     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (base_addr != ADDR_W'(RSVD_ADDR) && count != '0) begin
            wr_ptr_d = base_addr;
            remain_d = count;
            state_d  = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        ready = (remain_q != '0);
        beat  = in_valid && ready;
        if (beat) begin
          // Address 0 is the reserved empty slot, so the pointer skips it on wrap.
          wr_ptr_d = (wr_ptr_q == {ADDR_W{1'b1}}) ? ADDR_W'(1) : wr_ptr_q + ADDR_W'(1);
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end
        end
      end
      ST_SETTLE: begin
        // The first SETTLE cycle coincides with the final registered write.
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d = ST_DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      remain_q <= '0;
      settle_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      remain_q <= remain_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= beat;
      if (beat) begin
        addr_q <= wr_ptr_q;
        din_q  <= in_data;
      end
    end
  end

  assign in_ready  = ready;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_uram_writer.sv
// Randomized bench for vector_uram_writer: a burst-level model predicts every
// memory write (address, data, cycle), the done timing and the err pulses.
module tb_vector_uram_writer;
  import vector_uram_pkg::*;

  localparam int SIZE   = 256;
  localparam int AW     = 6;
  localparam int MAXA   = (1 << AW) - 1;
  localparam int WW     = AW + SIZE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   count = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [SIZE-1:0] mem_din;
  logic            busy;
  logic            done;
  logic            err;
  state_t          dbg_state;

  vector_uram_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [WW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [WW-1:0] last_word = '0;
  int err_cnt = 0, done_cnt = 0;
  int exp_err = 0, exp_done = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int base, input int i);
    return ((base - 1 + i) % MAXA) + 1;
  endfunction

  function automatic logic [SIZE-1:0] rand_vec();
    logic [SIZE-1:0] v;
    for (int k = 0; k < SIZE / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", {mem_addr, mem_din}, '0);
        end else begin
          logic [WW-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("we_addr_data", {mem_addr, mem_din}, e);
          check("we_cycle", cyc, ec);
          check("addr_nonzero", (mem_addr != '0), 1);
          last_word = e;
        end
      end else begin
        check("hold_addr_data", {mem_addr, mem_din}, last_word);
      end
      if (err) err_cnt++;
      if (done) done_cnt++;
    end
  end

  // ---------------- drivers ----------------
  // mode: 0 valid held, 1 valid toggled, 2 valid random,
  //       3 restart attempt during LOAD, 4 reset at 2nd beat
  task automatic run_burst(input int base, input int cnt, input int mode, input bit fixed);
    int i = 0, guard = 0, beat_cyc = 0;
    bit phase = 1'b0, v, aborted = 1'b0;
    @(posedge clk); #1;
    base_addr = AW'(base); count = AW'(cnt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (i < cnt && guard < 2000 && !aborted) begin
      case (mode)
        1:       v = (phase == 1'b0);
        2:       v = ($urandom_range(0, 1) == 1);
        default: v = 1'b1;
      endcase
      phase = ~phase;
      in_valid = v;
      in_data  = fixed ? SIZE'(32'hA + i) : rand_vec();
      @(negedge clk);
      if (guard == 0) check("busy_in_load", busy, 1);
      if (in_valid && in_ready) begin
        if (mode == 4 && i == 1) begin
          #1 rst = 1'b1;
          #1;
          check("rst_we_dropped", mem_we, 0);
          check("rst_state_idle", dbg_state, ST_IDLE);
          check("rst_busy", busy, 0);
          check("rst_ready", in_ready, 0);
          check("rst_queue_empty", exp_q.size(), 0);
          last_word = '0;
          in_valid = 1'b0;
          aborted = 1'b1;
        end else begin
          exp_q.push_back({AW'(exp_addr(base, i)), in_data});
          exp_cyc_q.push_back(cyc + 1);
          beat_cyc = cyc;
          i++;
          if (mode == 3 && i == 1) begin
            start = 1'b1; base_addr = AW'(9); count = AW'(1);
          end
        end
      end
      if (!aborted) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (aborted) begin
      int d0;
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(negedge clk);
      check("no_done_after_rst", done_cnt, d0);
      check("idle_after_rst", dbg_state, ST_IDLE);
    end else begin
      check("load_finished", i, cnt);
      @(negedge clk);
      check("ready_low_after_last", in_ready, 0);
      for (int k = 0; k < 12 && !done; k++) @(negedge clk);
      check("done_seen", done, 1);
      check("done_cycle", cyc, beat_cyc + 3);
      exp_done++;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  task automatic bad_start(input int base, input int cnt);
    @(posedge clk); #1;
    base_addr = AW'(base); count = AW'(cnt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err, 1);
    check("err_busy_low", busy, 0);
    exp_err++;
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_stay_idle", dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, c;
    @(negedge clk);
    check("reset_mem_we", mem_we, 0);
    check("reset_addr_din", {mem_addr, mem_din}, '0);
    check("reset_ready", in_ready, 0);
    check("reset_busy_done_err", {busy, done, err}, 3'b000);
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;

    run_burst(1, 2, 0, 1'b1);          // 0xA @1, 0xB @2
    bad_start(0, 3);
    bad_start(7, 0);
    run_burst(62, 3, 0, 1'b0);         // 62, 63, 1
    run_burst(10, 4, 1, 1'b0);         // toggled valid
    run_burst(20, 5, 4, 1'b0);         // reset at 2nd beat
    run_burst(5, 1, 0, 1'b0);
    run_burst(30, 3, 3, 1'b0);         // restart attempt ignored
    run_burst(40, 1, 3, 1'b0);

    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(1, MAXA);
      c = $urandom_range(1, 12);
      run_burst(b, c, $urandom_range(0, 2), 1'b0);
    end
    run_burst($urandom_range(1, MAXA), MAXA, 2, 1'b0);  // full wrap
    bad_start(0, 0);

    repeat (4) @(negedge clk);
    check("total_err_pulses", err_cnt, exp_err);
    check("total_done_pulses", done_cnt, exp_done);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
